// File: rtl/zero_crossing_detector.sv
// Registered first difference, hysteresis crossing pulses and windowed crossing count; latency 1 cycle.
// No backpressure: every cycle with sample_en=1 is consumed, and all state holds while sample_en=0.
module zero_crossing_detector #(
    parameter int WIDTH       = 4,
    parameter int HYST        = 1,
    parameter int WINDOW      = 1024,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic [WIDTH-1:0]       current_value,
    input  logic [WIDTH-1:0]       previous_value,
    output logic [WIDTH:0]         delta,
    output logic                   delta_valid,
    output logic                   rising,
    output logic                   falling,
    output logic [COUNT_WIDTH-1:0] crossings,
    output logic                   crossings_valid,
    output logic                   saturated
);

    localparam int CW = $clog2(WINDOW);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
    localparam logic signed [WIDTH:0] HI = (WIDTH+1)'(HYST);
    localparam logic signed [WIDTH:0] LO = (WIDTH+1)'(-HYST);

    typedef enum logic [1:0] {
        S_UNKNOWN = 2'd0,
        S_POS     = 2'd1,
        S_NEG     = 2'd2
    } sign_t;

    sign_t state, state_nxt;
    logic  rise_nxt, fall_nxt;

    logic signed [WIDTH:0] cur_ext, prev_ext, diff;
    logic                  above, below;

    logic [CW-1:0]          win;
    logic [COUNT_WIDTH-1:0] acc, acc_nxt;
    logic                   ovf, ovf_nxt;
    logic                   crossing, acc_max, win_end;

    // Sign extension to WIDTH+1 keeps the difference free of overflow.
    assign cur_ext  = {current_value[WIDTH-1], current_value};
    assign prev_ext = {previous_value[WIDTH-1], previous_value};
    assign diff     = cur_ext - prev_ext;
    assign above    = (cur_ext >= HI);
    assign below    = (cur_ext <= LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_UNKNOWN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (sample_en) begin
            case (state)
                S_UNKNOWN: begin
                    if (above) begin
                        state_nxt = S_POS;
                    end else if (below) begin
                        state_nxt = S_NEG;
                    end
                end
                S_POS: begin
                    if (below) begin
                        state_nxt = S_NEG;
                        fall_nxt  = 1'b1;
                    end
                end
                S_NEG: begin
                    if (above) begin
                        state_nxt = S_POS;
                        rise_nxt  = 1'b1;
                    end
                end
                default: state_nxt = S_UNKNOWN;
            endcase
        end
    end

    // Saturating accumulate; an increment attempted at the maximum marks overflow.
    always_comb begin
        crossing = rise_nxt | fall_nxt;
        acc_max  = &acc;
        acc_nxt  = acc;
        ovf_nxt  = ovf;
        if (crossing) begin
            if (acc_max) begin
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = acc + 1'b1;
            end
        end
        win_end = (win == WIN_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            delta           <= '0;
            delta_valid     <= 1'b0;
            rising          <= 1'b0;
            falling         <= 1'b0;
            crossings       <= '0;
            crossings_valid <= 1'b0;
            saturated       <= 1'b0;
            win             <= '0;
            acc             <= '0;
            ovf             <= 1'b0;
        end else begin
            delta_valid     <= sample_en;
            rising          <= rise_nxt;
            falling         <= fall_nxt;
            crossings_valid <= 1'b0;
            if (sample_en) begin
                delta <= diff;
                if (win_end) begin
                    crossings       <= acc_nxt;
                    saturated       <= ovf_nxt;
                    crossings_valid <= 1'b1;
                    acc             <= '0;
                    ovf             <= 1'b0;
                    win             <= '0;
                end else begin
                    acc <= acc_nxt;
                    ovf <= ovf_nxt;
                    win <= win + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zero_crossing_detector.sv
module tb_zero_crossing_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic [3:0] current_value;
    logic [3:0] previous_value;

    logic [4:0] a_delta;
    logic       a_dv, a_rise, a_fall, a_cv, a_sat;
    logic [7:0] a_cross;

    logic [4:0] b_delta;
    logic       b_dv, b_rise, b_fall, b_cv, b_sat;
    logic [2:0] b_cross;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    zero_crossing_detector #(.WIDTH(4), .HYST(1), .WINDOW(8), .COUNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .sample_en(sample_en),
        .current_value(current_value), .previous_value(previous_value),
        .delta(a_delta), .delta_valid(a_dv), .rising(a_rise), .falling(a_fall),
        .crossings(a_cross), .crossings_valid(a_cv), .saturated(a_sat)
    );

    zero_crossing_detector #(.WIDTH(4), .HYST(1), .WINDOW(16), .COUNT_WIDTH(3)) dut_b (
        .clk(clk), .rst(rst), .sample_en(sample_en),
        .current_value(current_value), .previous_value(previous_value),
        .delta(b_delta), .delta_valid(b_dv), .rising(b_rise), .falling(b_fall),
        .crossings(b_cross), .crossings_valid(b_cv), .saturated(b_sat)
    );

    // Apply one cycle of inputs, then settle just after the edge that samples them.
    task automatic step(input logic en, input logic [3:0] cur, input logic [3:0] prev);
        sample_en      = en;
        current_value  = cur;
        previous_value = prev;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 4'($urandom), 4'($urandom));
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 4'($urandom), 4'($urandom));
        step(1'b1, 4'($urandom), 4'($urandom));
        n_cmp++;
        if ({a_delta, a_dv, a_rise, a_fall, a_cross, a_cv, a_sat} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_a: got delta=%h dv=%b r=%b f=%b cr=%0d cv=%b sat=%b want all 0",
                     a_delta, a_dv, a_rise, a_fall, a_cross, a_cv, a_sat);
        end
        n_cmp++;
        if ({b_delta, b_dv, b_rise, b_fall, b_cross, b_cv, b_sat} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_b: got delta=%h dv=%b cr=%0d sat=%b want all 0", b_delta, b_dv, b_cross, b_sat);
        end
        rst = 1'b0;
        step(1'b1, 4'd0, 4'd0);
        n_cmp++;
        if ({a_dv, a_rise, a_fall, a_delta} !== {3'b100, 5'd0}) begin
            n_bad++;
            $display("FAIL reset_first_zero: got dv=%b r=%b f=%b delta=%h want dv=1 r=0 f=0 delta=0",
                     a_dv, a_rise, a_fall, a_delta);
        end
        // From UNKNOWN, entering NEG must not pulse.
        step(1'b1, 4'hF, 4'd0);
        n_cmp++;
        if ({a_rise, a_fall} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_unknown_exit: got r=%b f=%b want 0 0", a_rise, a_fall);
        end
    endtask

    task automatic test_delta();
        step(1'b1, 4'h8, 4'h7);
        n_cmp++;
        if ({a_dv, a_delta} !== {1'b1, 5'h11}) begin
            n_bad++;
            $display("FAIL delta_min: got dv=%b delta=%h want dv=1 delta=11", a_dv, a_delta);
        end
        step(1'b1, 4'h7, 4'h8);
        n_cmp++;
        if ({a_dv, a_delta} !== {1'b1, 5'h0F}) begin
            n_bad++;
            $display("FAIL delta_max: got dv=%b delta=%h want dv=1 delta=0f", a_dv, a_delta);
        end
        step(1'b1, 4'hD, 4'hD);
        n_cmp++;
        if ({a_dv, a_delta} !== {1'b1, 5'h00}) begin
            n_bad++;
            $display("FAIL delta_zero: got dv=%b delta=%h want dv=1 delta=00", a_dv, a_delta);
        end
        step(1'b0, 4'h7, 4'h8);
        n_cmp++;
        if ({a_dv, a_delta} !== {1'b0, 5'h00}) begin
            n_bad++;
            $display("FAIL delta_hold: got dv=%b delta=%h want dv=0 delta=00", a_dv, a_delta);
        end
    endtask

    task automatic test_hysteresis();
        logic [3:0] seq [9];
        logic [1:0] exp [9];
        seq = '{4'd3, 4'd0, 4'hF, 4'd0, 4'd0, 4'd1, 4'd2, 4'h8, 4'h8};
        exp = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, seq[i], 4'd0);
            n_cmp++;
            if ({a_rise, a_fall} !== exp[i]) begin
                n_bad++;
                $display("FAIL hyst_step%0d: got r/f=%b%b want %b", i, a_rise, a_fall, exp[i]);
            end
        end
    endtask

    task automatic test_window();
        logic [3:0] cur;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cur = (i % 2 == 0) ? 4'd2 : 4'hE;
            step(1'b1, cur, 4'd0);
            if (i == 7) begin
                n_cmp++;
                if ({a_cv, a_cross, a_sat} !== {1'b1, 8'd7, 1'b0}) begin
                    n_bad++;
                    $display("FAIL window1: got cv=%b cr=%0d sat=%b want 1 7 0", a_cv, a_cross, a_sat);
                end
            end else if (i == 15) begin
                n_cmp++;
                if ({a_cv, a_cross, a_sat} !== {1'b1, 8'd8, 1'b0}) begin
                    n_bad++;
                    $display("FAIL window2: got cv=%b cr=%0d sat=%b want 1 8 0", a_cv, a_cross, a_sat);
                end
            end else begin
                n_cmp++;
                if (a_cv !== 1'b0) begin
                    n_bad++;
                    $display("FAIL window_cv_early%0d: got cv=%b want 0", i, a_cv);
                end
            end
        end
        step(1'b0, 4'd2, 4'd0);
        n_cmp++;
        if ({a_cv, a_cross} !== {1'b0, 8'd8}) begin
            n_bad++;
            $display("FAIL window_hold: got cv=%b cr=%0d want 0 8", a_cv, a_cross);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 2 == 0) ? 4'hE : 4'd2, 4'd0);
        end
        n_cmp++;
        if ({b_cv, b_cross, b_sat} !== {1'b1, 3'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL sat_window: got cv=%b cr=%0d sat=%b want 1 7 1", b_cv, b_cross, b_sat);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'd2, 4'd0);
            if (i == 0) begin
                n_cmp++;
                if ({b_cv, b_cross, b_sat} !== {1'b0, 3'd7, 1'b1}) begin
                    n_bad++;
                    $display("FAIL sat_hold: got cv=%b cr=%0d sat=%b want 0 7 1", b_cv, b_cross, b_sat);
                end
            end
        end
        n_cmp++;
        if ({b_cv, b_cross, b_sat} !== {1'b1, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL sat_clear: got cv=%b cr=%0d sat=%b want 1 0 0", b_cv, b_cross, b_sat);
        end
    endtask

    task automatic test_gaps_and_reset();
        logic [4:0] exp_delta;
        logic [7:0] exp_cross;
        logic [1:0] exp_rf;
        int         k;
        do_reset();
        exp_delta = 5'd0;
        exp_cross = 8'd0;
        for (int i = 0; i < 16; i++) begin
            k = i / 2;
            if (i % 2 == 0) begin
                step(1'b1, (k % 2 == 0) ? 4'd2 : 4'hE, 4'd0);
                exp_delta = (k % 2 == 0) ? 5'd2 : 5'h1E;
                exp_rf    = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
                if (k == 7) exp_cross = 8'd7;
                n_cmp++;
                if ({a_dv, a_rise, a_fall, a_cv, a_delta, a_cross} !==
                    {1'b1, exp_rf, (k == 7), exp_delta, exp_cross}) begin
                    n_bad++;
                    $display("FAIL gap_en%0d: got dv=%b rf=%b%b cv=%b d=%h cr=%0d want 1 %b %b %h %0d",
                             k, a_dv, a_rise, a_fall, a_cv, a_delta, a_cross, exp_rf, (k == 7), exp_delta, exp_cross);
                end
            end else begin
                step(1'b0, 4'($urandom), 4'($urandom));
                n_cmp++;
                if ({a_dv, a_rise, a_fall, a_cv, a_delta, a_cross, a_sat} !==
                    {4'b0000, exp_delta, exp_cross, 1'b0}) begin
                    n_bad++;
                    $display("FAIL gap_idle%0d: got dv=%b rf=%b%b cv=%b d=%h cr=%0d want 0 00 0 %h %0d",
                             k, a_dv, a_rise, a_fall, a_cv, a_delta, a_cross, exp_delta, exp_cross);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i % 2 == 0) ? 4'd2 : 4'hE, 4'd0);
        end
        rst = 1'b1;
        step(1'b1, 4'd2, 4'd0);
        rst = 1'b0;
        n_cmp++;
        if ({a_dv, a_cross, a_cv, a_delta} !== 15'd0) begin
            n_bad++;
            $display("FAIL midreset: got dv=%b cr=%0d cv=%b d=%h want all 0", a_dv, a_cross, a_cv, a_delta);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 2 == 0) ? 4'd2 : 4'hE, 4'd0);
            n_cmp++;
            if ({a_cv, a_cross} !== ((i == 7) ? {1'b1, 8'd7} : {1'b0, 8'd0})) begin
                n_bad++;
                $display("FAIL postreset%0d: got cv=%b cr=%0d want cv=%b cr=%0d",
                         i, a_cv, a_cross, (i == 7), (i == 7) ? 7 : 0);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        sample_en      = 1'b0;
        current_value  = 4'd0;
        previous_value = 4'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_delta();
        test_hysteresis();
        test_window();
        test_saturation();
        test_gaps_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zero_crossing_detector.md
Name: zero_crossing_detector

Overview:
Downstream consumer of the previous-value delay stage. Takes each current signed sample and the preceding sample from the delay stage, and produces a registered first difference. A hysteresis sign tracker emits rising and falling crossing pulses. Crossings are counted over a fixed window of enabled samples, which gives a frequency estimate for the LED/display logic.

Parameters:
WIDTH, 4, sample width in bits (signed two's complement)
HYST, 1, hysteresis threshold magnitude; legal range 1..2^(WIDTH-1)-1
WINDOW, 1024, number of enabled samples per measurement window; must be >= 2
COUNT_WIDTH, 8, width of the crossing count output

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
sample_en  input  1  qualifies current_value/previous_value for this cycle
current_value  input  WIDTH  signed current sample
previous_value  input  WIDTH  signed previous sample from the delay stage
delta  output  WIDTH+1  signed registered current_value - previous_value
delta_valid  output  1  one-cycle pulse, delta updated
rising  output  1  one-cycle pulse, NEG->POS transition
falling  output  1  one-cycle pulse, POS->NEG transition
crossings  output  COUNT_WIDTH  crossing count of last completed window
crossings_valid  output  1  one-cycle pulse, crossings updated
saturated  output  1  last completed window overflowed the count

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- All outputs are registered. The response to a sample appears on the cycle after the clk edge where sample_en=1 (latency 1).
- Reset: sign state=UNKNOWN; window counter=0; accumulator=0; overflow flag=0. Outputs: delta=0, delta_valid=0, rising=0, falling=0, crossings=0, crossings_valid=0, saturated=0. rst has priority over sample_en.
- sample_en=0: state, counters, delta, crossings and saturated hold. delta_valid, rising, falling and crossings_valid are 0.
- Delta: both inputs are sign-extended to WIDTH+1 before subtraction, so there is no overflow. For WIDTH=4 the range is -15..+15.
- Sign FSM (evaluates current_value only, on sample_en):
  - UNKNOWN: cur >= HYST -> POS; cur <= -HYST -> NEG; otherwise stay. No pulse on leaving UNKNOWN.
  - POS: cur <= -HYST -> NEG with falling=1; otherwise stay.
  - NEG: cur >= HYST -> POS with rising=1; otherwise stay.
  - Values strictly inside (-HYST, HYST) never change state.
  - A direct jump across the band (e.g. +7 to -8) is a single transition with a single pulse.
- Window counter counts enabled samples 0..WINDOW-1 and then wraps to 0.
- Accumulator adds 1 for each rising or falling transition. It saturates at 2^COUNT_WIDTH-1; any increment attempted at that maximum sets the overflow flag.
- Window end (the enabled sample where the window counter = WINDOW-1):
  - crossings <= accumulator plus this sample's crossing, saturated.
  - saturated <= overflow flag, including overflow caused by this sample.
  - crossings_valid=1 for one cycle.
  - Accumulator, overflow flag and window counter clear to 0.
  - The sign FSM state is not cleared; crossings that straddle windows are counted in the window where the transition occurs.
- crossings and saturated hold between window ends.
- Reset mid-window discards the partial window. The next crossings_valid follows WINDOW enabled samples after rst deasserts.
- Implementation: counters sized to clog2(WINDOW); no combinational path from any input to any output.

Test Plan:
1. Reset: hold rst 2 cycles with sample_en=1 and random data -> all outputs 0. Release, then send cur=0 -> state stays UNKNOWN, no pulses, delta_valid=1 next cycle.
2. Delta extremes: prev=7, cur=-8 -> delta=-15, delta_valid pulse next cycle. prev=-8, cur=7 -> delta=+15. prev=-3, cur=-3 -> delta=0.
3. Hysteresis (HYST=1): cur sequence 3,0,-1,0,0,1 -> no pulse on 3 (from UNKNOWN), falling on -1, rising on 1, no pulses on the 0s. Sequence 2,-8 (jump) -> exactly one falling pulse.
4. Window count (WINDOW=8): continuous sample_en, cur alternating +2,-2 starting +2 -> crossings=7 with crossings_valid one cycle after the 8th sample; next window -> crossings=8, saturated=0.
5. Saturation (COUNT_WIDTH=3, WINDOW=16): alternating +2,-2 -> crossings=7, saturated=1 at window end; next window with constant +2 -> crossings=0, saturated=0.
6. Gaps and mid-window reset (WINDOW=8): sample_en toggling every other cycle -> window end after 8 enabled samples, not 8 cycles, and all outputs hold during gaps. Assert rst after enabled sample 5 -> no crossings_valid until 8 enabled samples after release.
